reg_writeback: RTL and testbench
================================

# reg_writeback

Writeback stage that drives the register file's single write port (reg_waddr/reg_wdata/reg_wen) from two sources: single-cycle ALU results from execution and delayed load data from data memory. It tracks one outstanding load and buffers ALU results in a 2-entry FIFO while a load return occupies the port. It also raises a hazard stall to instruction decode for any register whose write is not yet visible at the register file.

## Interface
- DATA_W, 32, register data width
- ADDR_W, 5, register address width
- sys_clk  in  1  clock, all state updates on rising edge
- sys_rst  in  1  synchronous active-high reset
- ex_valid  in  1  execution offers a writeback beat
- ex_ready  out  1  beat accepted when ex_valid && ex_ready
- ex_is_load  in  1  beat is a load; data arrives later on mem_rdata; ex_wdata ignored
- ex_waddr  in  ADDR_W  destination register
- ex_wdata  in  DATA_W  ALU result
- mem_rvalid  in  1  load data valid, single-cycle pulse
- mem_rdata  in  DATA_W  load data
- id_rs1, id_rs2  in  ADDR_W  decode source registers
- hazard_stall  out  1  decode must hold this cycle
- reg_waddr  out  ADDR_W  to register file, registered
- reg_wdata  out  DATA_W  to register file, registered
- reg_wen  out  1  to register file, registered

## Operation
- States: IDLE (no load outstanding), LOAD_WAIT (one load outstanding, pend_rd held).
- IDLE: accepted load beat -> capture pend_rd, go to LOAD_WAIT. Accepted non-load beat -> push to FIFO, or bypass if FIFO empty.
- LOAD_WAIT: mem_rvalid -> issue the load write, go to IDLE. Non-load beats are still accepted into the FIFO.
- Write-port priority each cycle: load return > FIFO head > bypassed ex beat. At most one write per cycle.
- ex_ready = !fifo_full && !(state==LOAD_WAIT && ex_is_load). ex_ready is combinational on ex_is_load.
- Simultaneous accepted ex beat and FIFO pop: both happen; occupancy is unchanged.
- x0 destination: a non-load beat is consumed with no write and no FIFO entry. A load to x0 still enters LOAD_WAIT, but its return produces no write.
- mem_rvalid in IDLE: ignored, no write.
- hazard_stall = any nonzero id_rs1/id_rs2 equal to (pend_rd while in LOAD_WAIT and not killed) or to the waddr of any valid FIFO entry.
- The register file forwards only the write port in the same cycle, so stalls cover everything not yet on the port.

## Timing
- Reset values: reg_wen=0, reg_waddr=0, reg_wdata=0, state=IDLE, FIFO empty, kill=0, hazard_stall=0.
- ALU beat accepted in cycle N with no contention -> reg_wen high in cycle N+1.
- mem_rvalid in cycle M -> reg_wen high in cycle M+1 with mem_rdata. A FIFO head delayed by this resumes in cycle M+2.
- reg_wen is high for exactly one cycle per write.
- Reset asserted mid-operation: FIFO flushed, outstanding load forgotten, reg_wen=0 in the following cycle. mem_rvalid arriving during or after reset with no load outstanding is dropped.

## Configuration
- WB_WAW_KILL_EN defined: a non-load beat to pend_rd accepted during LOAD_WAIT sets kill. The load return then completes the state transition without writing, so the younger ALU value wins. hazard_stall stops matching pend_rd once kill is set.
- WB_WAW_KILL_EN undefined: ex_ready is deasserted for any beat with ex_waddr==pend_rd during LOAD_WAIT until the load has written.

## Structure
- Shared package riscv_wb_pkg: DATA_W and REG_ADDR_W defaults, the state encoding (IDLE, LOAD_WAIT), and the FIFO depth constant (2).
- One sub-module, wb_fifo: 2-entry {waddr, wdata} FIFO with push/pop/full/empty and per-entry valid+waddr outputs for hazard compare.
- The FSM, priority mux, and output registers stay in reg_writeback.

## Test plan
- ALU beat x5=0x1234 in cycle 3 -> reg_wen=1, reg_waddr=5, reg_wdata=0x1234 in cycle 4 only.
- Load to x7, mem_rvalid with 0xCAFEBABE three cycles later -> hazard_stall=1 for id_rs1=7 until the return; write x7=0xCAFEBABE the cycle after mem_rvalid.
- During LOAD_WAIT push ALU beats x3=1 and x4=2, then present x6=3: x6 stalls on ex_ready=0 (FIFO full). mem_rvalid in the same cycle as a pop -> port order is load, x3, x4, then x6.
- Load to x8 followed by ALU x8=0x55 (WB_WAW_KILL_EN on) -> only x8=0x55 written, the load return is dropped. With the macro off -> ex_ready=0 until the load writes, then x8=0x55.
- Beats to x0, plus a load to x0 with its return -> reg_wen stays 0 throughout, and hazard_stall stays 0 for id_rs1=0.
- sys_rst asserted while in LOAD_WAIT with 2 FIFO entries, mem_rvalid pulsed after reset -> no writes occur and state is IDLE.

Source files
------------

// File: rtl/riscv_wb_pkg.sv
// rtl/riscv_wb_pkg.sv - shared widths, FSM encoding and FIFO depth for the writeback stage
package riscv_wb_pkg;

  localparam int DEF_DATA_W     = 32;
  localparam int DEF_REG_ADDR_W = 5;
  localparam int FIFO_DEPTH     = 2;

  typedef enum logic {
    ST_IDLE      = 1'b0,
    ST_LOAD_WAIT = 1'b1
  } wb_state_e;

endpackage

// File: rtl/wb_fifo.sv
// rtl/wb_fifo.sv - small {waddr, wdata} FIFO with per-entry valid/waddr taps for hazard compare
module wb_fifo #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push,
  input  logic [ADDR_W-1:0]       push_waddr,
  input  logic [DATA_W-1:0]       push_wdata,
  input  logic                    pop,
  output logic                    full,
  output logic                    empty,
  output logic [ADDR_W-1:0]       head_waddr,
  output logic [DATA_W-1:0]       head_wdata,
  output logic [DEPTH-1:0]        ent_valid,
  output logic [DEPTH*ADDR_W-1:0] ent_waddr
);

  // DEPTH is expected to be a power of two so the pointers wrap naturally.
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [ADDR_W-1:0] mem_waddr [DEPTH];
  logic [DATA_W-1:0] mem_wdata [DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W:0]    count;
  logic              do_push;
  logic              do_pop;

  assign full       = (count == (PTR_W+1)'(DEPTH));
  assign empty      = (count == '0);
  assign do_push    = push && !full;
  assign do_pop     = pop && !empty;
  assign head_waddr = mem_waddr[rd_ptr];
  assign head_wdata = mem_wdata[rd_ptr];

  // Pointer and occupancy bookkeeping; a simultaneous push and pop leaves count unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (!do_push && do_pop) count <= count - 1'b1;
    end
  end

  // Entry storage; contents need no reset because validity is tracked by count.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_waddr[wr_ptr] <= push_waddr;
      mem_wdata[wr_ptr] <= push_wdata;
    end
  end

  // An entry is live when its distance from the read pointer is below the occupancy.
  always_comb begin
    ent_valid = '0;
    ent_waddr = '0;
    for (int i = 0; i < DEPTH; i++) begin
      ent_valid[i] = ({1'b0, PTR_W'(PTR_W'(i) - rd_ptr)} < count);
      ent_waddr[i*ADDR_W +: ADDR_W] = mem_waddr[i];
    end
  end

endmodule

// File: rtl/reg_writeback.sv
// rtl/reg_writeback.sv - register-file write port arbiter for ALU results and one outstanding load; WB_WAW_KILL_EN selects kill-on-WAW instead of WAW backpressure
module reg_writeback
  import riscv_wb_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_REG_ADDR_W
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic              ex_is_load,
  input  logic [ADDR_W-1:0] ex_waddr,
  input  logic [DATA_W-1:0] ex_wdata,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic [ADDR_W-1:0] id_rs1,
  input  logic [ADDR_W-1:0] id_rs2,
  output logic              hazard_stall,
  output logic [ADDR_W-1:0] reg_waddr,
  output logic [DATA_W-1:0] reg_wdata,
  output logic              reg_wen
);

  wb_state_e state;
  wb_state_e next_state;

  logic [ADDR_W-1:0]            pend_rd;
  logic                         ex_fire;
  logic                         alu_fire;
  logic                         load_fire;
  logic                         load_ret;
  logic                         kill;
  logic                         kill_now;
  logic                         fifo_push;
  logic                         fifo_pop;
  logic                         fifo_full;
  logic                         fifo_empty;
  logic [ADDR_W-1:0]            fifo_head_waddr;
  logic [DATA_W-1:0]            fifo_head_wdata;
  logic [FIFO_DEPTH-1:0]        fifo_ent_valid;
  logic [FIFO_DEPTH*ADDR_W-1:0] fifo_ent_waddr;
  logic                         wr_en;
  logic [ADDR_W-1:0]            wr_addr;
  logic [DATA_W-1:0]            wr_data;

  assign ex_fire   = ex_valid && ex_ready;
  assign alu_fire  = ex_fire && !ex_is_load && (ex_waddr != '0);
  assign load_fire = ex_fire && ex_is_load;
  assign load_ret  = (state == ST_LOAD_WAIT) && mem_rvalid;

`ifdef WB_WAW_KILL_EN
  logic kill_hit;

  // A younger ALU write to the pending load's destination supersedes the load data.
  assign kill_hit = (state == ST_LOAD_WAIT) && ex_fire && !ex_is_load && (ex_waddr == pend_rd);
  assign kill_now = kill || kill_hit;

  // Kill lives only for the current load; cleared when the load returns or none is outstanding.
  always_ff @(posedge sys_clk) begin
    if (sys_rst || load_ret || state == ST_IDLE) kill <= 1'b0;
    else if (kill_hit)                           kill <= 1'b1;
  end
`else
  assign kill     = 1'b0;
  assign kill_now = 1'b0;
`endif

  // Backpressure: FIFO full, a second load, or (without kill) a WAW against the pending load.
  always_comb begin
    ex_ready = !fifo_full && !(state == ST_LOAD_WAIT && ex_is_load);
`ifndef WB_WAW_KILL_EN
    if (state == ST_LOAD_WAIT && ex_waddr == pend_rd) ex_ready = 1'b0;
`endif
  end

  // FSM state register.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) state <= ST_IDLE;
    else         state <= next_state;
  end

  // FSM next state: one load in flight at a time; mem_rvalid with no load pending is ignored.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:      if (load_fire)  next_state = ST_LOAD_WAIT;
      ST_LOAD_WAIT: if (mem_rvalid) next_state = ST_IDLE;
      default:                      next_state = ST_IDLE;
    endcase
  end

  // FSM outputs: port arbitration load return > FIFO head > bypass. The FIFO is held while a
  // load is outstanding so the older load reaches the port ahead of younger ALU results.
  always_comb begin
    wr_en    = 1'b0;
    wr_addr  = pend_rd;
    wr_data  = mem_rdata;
    fifo_pop = 1'b0;
    if (load_ret) begin
      wr_en = !kill_now && (pend_rd != '0);
    end else if (state == ST_IDLE && !fifo_empty) begin
      fifo_pop = 1'b1;
      wr_en    = 1'b1;
      wr_addr  = fifo_head_waddr;
      wr_data  = fifo_head_wdata;
    end else if (state == ST_IDLE && alu_fire) begin
      wr_en   = 1'b1;
      wr_addr = ex_waddr;
      wr_data = ex_wdata;
    end
    fifo_push = alu_fire && !(state == ST_IDLE && fifo_empty);
  end

  // Capture the destination of an accepted load.
  always_ff @(posedge sys_clk) begin
    if (sys_rst)        pend_rd <= '0;
    else if (load_fire) pend_rd <= ex_waddr;
  end

  // Registered write port; address/data hold between writes.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      reg_wen   <= 1'b0;
      reg_waddr <= '0;
      reg_wdata <= '0;
    end else begin
      reg_wen <= wr_en;
      if (wr_en) begin
        reg_waddr <= wr_addr;
        reg_wdata <= wr_data;
      end
    end
  end

  // Stall decode on any nonzero source whose write has not yet reached the port.
  always_comb begin
    hazard_stall = 1'b0;
    if (state == ST_LOAD_WAIT && !kill && pend_rd != '0 &&
        (id_rs1 == pend_rd || id_rs2 == pend_rd))
      hazard_stall = 1'b1;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (fifo_ent_valid[i]) begin
        if (id_rs1 != '0 && id_rs1 == fifo_ent_waddr[i*ADDR_W +: ADDR_W]) hazard_stall = 1'b1;
        if (id_rs2 != '0 && id_rs2 == fifo_ent_waddr[i*ADDR_W +: ADDR_W]) hazard_stall = 1'b1;
      end
    end
  end

  wb_fifo #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk        (sys_clk),
    .rst        (sys_rst),
    .push       (fifo_push),
    .push_waddr (ex_waddr),
    .push_wdata (ex_wdata),
    .pop        (fifo_pop),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .head_waddr (fifo_head_waddr),
    .head_wdata (fifo_head_wdata),
    .ent_valid  (fifo_ent_valid),
    .ent_waddr  (fifo_ent_waddr)
  );

endmodule

// File: tb/tb_reg_writeback.sv
// tb/tb_reg_writeback.sv - directed and randomized checks of reg_writeback against a queue model; honours WB_WAW_KILL_EN
module tb_reg_writeback;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic        ex_valid;
  logic        ex_ready;
  logic        ex_is_load;
  logic [4:0]  ex_waddr;
  logic [31:0] ex_wdata;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic        hazard_stall;
  logic [4:0]  reg_waddr;
  logic [31:0] reg_wdata;
  logic        reg_wen;

  always #5 sys_clk = ~sys_clk;

  reg_writeback dut (
    .sys_clk      (sys_clk),
    .sys_rst      (sys_rst),
    .ex_valid     (ex_valid),
    .ex_ready     (ex_ready),
    .ex_is_load   (ex_is_load),
    .ex_waddr     (ex_waddr),
    .ex_wdata     (ex_wdata),
    .mem_rvalid   (mem_rvalid),
    .mem_rdata    (mem_rdata),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .hazard_stall (hazard_stall),
    .reg_waddr    (reg_waddr),
    .reg_wdata    (reg_wdata),
    .reg_wen      (reg_wen)
  );

  int vectors     = 0;
  int miscompares = 0;
  bit chk_en      = 1'b0;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
  } wr_t;

  wr_t         m_q[$];
  bit          m_load;
  bit          m_kill;
  logic [4:0]  m_pend;
  bit          m_wen;
  logic [4:0]  m_waddr;
  logic [31:0] m_wdata;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit f_ready();
    f_ready = (m_q.size() < 2) && !(m_load && ex_is_load);
`ifndef WB_WAW_KILL_EN
    if (m_load && ex_waddr == m_pend) f_ready = 1'b0;
`endif
  endfunction

  function automatic bit f_busy(input logic [4:0] r);
    if (r == 5'd0) return 1'b0;
    if (m_load && !m_kill && r == m_pend) return 1'b1;
    foreach (m_q[i]) if (m_q[i].addr == r) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_step();
    bit fire, ret, alu, killnow, bypass;
    wr_t w;
    if (sys_rst) begin
      m_q.delete();
      m_load = 0; m_kill = 0; m_pend = '0;
      m_wen = 0; m_waddr = '0; m_wdata = '0;
      return;
    end
    fire    = ex_valid && f_ready();
    ret     = m_load && mem_rvalid;
    alu     = fire && !ex_is_load && ex_waddr != 5'd0;
    bypass  = 0;
    m_wen   = 0;
    killnow = m_kill;
`ifdef WB_WAW_KILL_EN
    if (m_load && fire && !ex_is_load && ex_waddr == m_pend) killnow = 1;
`endif
    if (ret) begin
      if (!killnow && m_pend != 5'd0) begin
        m_wen = 1; m_waddr = m_pend; m_wdata = mem_rdata;
      end
    end else if (!m_load && m_q.size() > 0) begin
      w = m_q.pop_front();
      m_wen = 1; m_waddr = w.addr; m_wdata = w.data;
    end else if (!m_load && alu) begin
      bypass = 1;
      m_wen = 1; m_waddr = ex_waddr; m_wdata = ex_wdata;
    end
    if (alu && !bypass) m_q.push_back('{ex_waddr, ex_wdata});
    if (ret) begin
      m_load = 0; m_kill = 0;
    end else if (m_load) begin
      m_kill = killnow;
    end
    if (fire && ex_is_load) begin
      m_load = 1; m_pend = ex_waddr; m_kill = 0;
    end
  endtask

  always @(negedge sys_clk) begin
    if (chk_en) begin
      chk("ex_ready", 32'(ex_ready), 32'(f_ready()));
      chk("hazard_stall", 32'(hazard_stall), 32'(f_busy(id_rs1) || f_busy(id_rs2)));
      chk("reg_wen", 32'(reg_wen), 32'(m_wen));
      if (m_wen) begin
        chk("reg_waddr", 32'(reg_waddr), 32'(m_waddr));
        chk("reg_wdata", reg_wdata, m_wdata);
      end
    end
    model_step();
  end

  task automatic cyc();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic idle_in();
    ex_valid = 0; ex_is_load = 0; ex_waddr = '0; ex_wdata = '0;
    mem_rvalid = 0; mem_rdata = '0; id_rs1 = '0; id_rs2 = '0;
  endtask

  task automatic beat(input logic ld, input logic [4:0] a, input logic [31:0] d);
    ex_valid = 1; ex_is_load = ld; ex_waddr = a; ex_wdata = d;
  endtask

  initial begin
    idle_in();
    sys_rst = 1;
    cyc(); cyc();
    chk_en = 1;
    id_rs1 = 5'd5; id_rs2 = 5'd7;
    @(negedge sys_clk);
    chk("rst_wen", 32'(reg_wen), 0);
    chk("rst_waddr", 32'(reg_waddr), 0);
    chk("rst_wdata", reg_wdata, 0);
    chk("rst_hazard", 32'(hazard_stall), 0);
    cyc();
    sys_rst = 0; idle_in();
    cyc();

    // single ALU beat, one-cycle latency, one-cycle pulse
    beat(0, 5'd5, 32'h1234);
    @(negedge sys_clk); chk("alu_ready", 32'(ex_ready), 1);
    cyc(); ex_valid = 0;
    @(negedge sys_clk);
    chk("alu_wen", 32'(reg_wen), 1);
    chk("alu_waddr", 32'(reg_waddr), 5);
    chk("alu_wdata", reg_wdata, 32'h1234);
    cyc();
    @(negedge sys_clk); chk("alu_wen_drop", 32'(reg_wen), 0);

    // load to x7 with return three cycles later
    cyc(); beat(1, 5'd7, 0);
    cyc(); ex_valid = 0; id_rs1 = 5'd7;
    @(negedge sys_clk); chk("ld_haz1", 32'(hazard_stall), 1);
    cyc();
    @(negedge sys_clk); chk("ld_haz2", 32'(hazard_stall), 1);
    cyc(); mem_rvalid = 1; mem_rdata = 32'hCAFEBABE;
    @(negedge sys_clk);
    chk("ld_haz3", 32'(hazard_stall), 1);
    chk("ld_wen_pre", 32'(reg_wen), 0);
    cyc(); mem_rvalid = 0;
    @(negedge sys_clk);
    chk("ld_wen", 32'(reg_wen), 1);
    chk("ld_waddr", 32'(reg_waddr), 7);
    chk("ld_wdata", reg_wdata, 32'hCAFEBABE);
    chk("ld_haz_clr", 32'(hazard_stall), 0);
    cyc(); id_rs1 = '0;

    // FIFO fills behind a load, then drains in program order
    beat(1, 5'd2, 0);
    cyc(); beat(0, 5'd3, 32'd1);
    cyc(); beat(0, 5'd4, 32'd2);
    cyc(); beat(0, 5'd6, 32'd3); mem_rvalid = 1; mem_rdata = 32'h0BADF00D;
    @(negedge sys_clk); chk("full_ready", 32'(ex_ready), 0);
    cyc(); mem_rvalid = 0;
    @(negedge sys_clk);
    chk("ord0_addr", 32'(reg_waddr), 2);
    chk("ord0_data", reg_wdata, 32'h0BADF00D);
    chk("ord0_ready", 32'(ex_ready), 0);
    cyc();
    @(negedge sys_clk);
    chk("ord1_addr", 32'(reg_waddr), 3);
    chk("ord1_data", reg_wdata, 32'd1);
    chk("ord1_ready", 32'(ex_ready), 1);
    cyc(); ex_valid = 0;
    @(negedge sys_clk);
    chk("ord2_addr", 32'(reg_waddr), 4);
    chk("ord2_data", reg_wdata, 32'd2);
    cyc();
    @(negedge sys_clk);
    chk("ord3_wen", 32'(reg_wen), 1);
    chk("ord3_addr", 32'(reg_waddr), 6);
    chk("ord3_data", reg_wdata, 32'd3);
    cyc();
    @(negedge sys_clk); chk("ord_done", 32'(reg_wen), 0);

    // WAW between a pending load and a younger ALU write to x8
    cyc(); idle_in(); beat(1, 5'd8, 0);
    cyc(); beat(0, 5'd8, 32'h55);
`ifdef WB_WAW_KILL_EN
    @(negedge sys_clk); chk("waw_ready", 32'(ex_ready), 1);
    cyc(); ex_valid = 0; id_rs1 = 5'd8;
    @(negedge sys_clk); chk("waw_haz", 32'(hazard_stall), 1);
    cyc(); mem_rvalid = 1; mem_rdata = 32'h77;
    cyc(); mem_rvalid = 0;
    @(negedge sys_clk); chk("waw_killed", 32'(reg_wen), 0);
    cyc();
    @(negedge sys_clk);
    chk("waw_wen", 32'(reg_wen), 1);
    chk("waw_addr", 32'(reg_waddr), 8);
    chk("waw_data", reg_wdata, 32'h55);
`else
    @(negedge sys_clk); chk("waw_ready0", 32'(ex_ready), 0);
    cyc();
    @(negedge sys_clk); chk("waw_ready1", 32'(ex_ready), 0);
    cyc(); mem_rvalid = 1; mem_rdata = 32'h77;
    @(negedge sys_clk); chk("waw_ready2", 32'(ex_ready), 0);
    cyc(); mem_rvalid = 0;
    @(negedge sys_clk);
    chk("waw_ld_addr", 32'(reg_waddr), 8);
    chk("waw_ld_data", reg_wdata, 32'h77);
    chk("waw_ready3", 32'(ex_ready), 1);
    cyc(); ex_valid = 0;
    @(negedge sys_clk);
    chk("waw_wen", 32'(reg_wen), 1);
    chk("waw_addr", 32'(reg_waddr), 8);
    chk("waw_data", reg_wdata, 32'h55);
`endif
    cyc(); idle_in();
    cyc();

    // x0 destinations never reach the port and never stall
    for (int i = 0; i < 8; i++) begin
      idle_in();
      case (i)
        0: beat(0, 5'd0, 32'hDEAD);
        1: beat(1, 5'd0, 0);
        3: beat(0, 5'd0, 32'd1);
        4: begin mem_rvalid = 1; mem_rdata = 32'h1111; end
        default: ;
      endcase
      @(negedge sys_clk);
      chk("x0_wen", 32'(reg_wen), 0);
      chk("x0_haz", 32'(hazard_stall), 0);
      cyc();
    end

    // reset while a load and two FIFO entries are pending
    idle_in(); beat(1, 5'd9, 0);
    cyc(); beat(0, 5'd10, 32'hA);
    cyc(); beat(0, 5'd11, 32'hB);
    cyc(); ex_valid = 0; sys_rst = 1; mem_rvalid = 1; mem_rdata = 32'h5555;
    @(negedge sys_clk); chk("rr_wen0", 32'(reg_wen), 0);
    cyc(); sys_rst = 0; id_rs1 = 5'd9; id_rs2 = 5'd10; ex_is_load = 1; ex_waddr = 5'd9;
    @(negedge sys_clk);
    chk("rr_wen1", 32'(reg_wen), 0);
    chk("rr_haz", 32'(hazard_stall), 0);
    chk("rr_ready", 32'(ex_ready), 1);
    cyc(); mem_rvalid = 0;
    @(negedge sys_clk); chk("rr_wen2", 32'(reg_wen), 0);
    cyc();
    @(negedge sys_clk); chk("rr_wen3", 32'(reg_wen), 0);
    cyc();

    // randomized traffic against the model
    for (int n = 0; n < 4000; n++) begin
      ex_valid   = ($urandom_range(0, 99) < 60);
      ex_is_load = ($urandom_range(0, 99) < 20);
      ex_waddr   = 5'($urandom_range(0, 15));
      ex_wdata   = $urandom;
      mem_rvalid = ($urandom_range(0, 99) < 25);
      mem_rdata  = $urandom;
      id_rs1     = 5'($urandom_range(0, 15));
      id_rs2     = 5'($urandom_range(0, 15));
      sys_rst    = ($urandom_range(0, 299) == 0);
      cyc();
    end
    idle_in(); sys_rst = 0;
    cyc(); cyc();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
